pcie_rd_tag_mgr: RTL and testbench
==================================

Name: pcie_rd_tag_mgr

Overview:
Parametrised non-posted read tag manager for the requester (RQ/RC) path. It allocates tags to outgoing memory-read TLPs and retires them on the final completion. It ages outstanding tags against a programmable timeout and, optionally, recovers timed-out tags. It generalises the fixed 32/64-tag handling in pcie_user_top to any power-of-two tag count, with a backpressured timeout report channel.

Parameters:
MAXTAG, 64, number of tags; power of two, 8..256
TAGW, $clog2(MAXTAG), tag index width (derived)
TOUT_W, 16, width of timeout threshold and tick timestamp
TICK_DIV, 1024, pcie_clk cycles per timeout tick; must be at least 2

Ports:
pcie_clk  in  1  clock
pcie_rst_n  in  1  asynchronous active-low reset
iTAG_recovery  in  1  1 = free a tag when its timeout is reported
iTAG_tout_set  in  TOUT_W  timeout threshold in ticks; 0 disables timeout
alloc_req  in  1  requester wants a tag
alloc_gnt  out  1  tag granted this cycle
alloc_tag  out  TAGW  granted tag (valid with alloc_gnt)
cpl_valid  in  1  completion beat header valid
cpl_tag  in  TAGW  completion tag
cpl_end  in  1  last completion for this request (byte count exhausted)
tout_valid  out  1  timeout report valid
tout_tag  out  TAGW  timed-out tag
tout_ready  in  1  consumer accepts report
free_cnt  out  TAGW+1  number of free tags
cpl_err_flg  out  1  one-cycle pulse: completion for a non-busy tag
tag_timeout_flg_dbg  out  1  sticky: any timeout occurred since reset

Behaviour:
- Reset (async assert, sync release): all tags free, free_cnt=MAXTAG, tick/prescaler/scan index=0, FSM=SCAN. All other outputs are 0.
- State per tag: busy bit, timed_out bit, TOUT_W-bit timestamp (register array or distributed RAM).
- Prescaler counts 0..TICK_DIV-1. On wrap, now_tick increments modulo 2^TOUT_W.
- Allocation:
  - alloc_gnt = alloc_req & (free_cnt != 0), combinational from registered state.
  - alloc_tag = lowest-index free tag.
  - On grant: busy<=1, timed_out<=0, stamp<=now_tick, effective next edge.
  - free_cnt==0: alloc_gnt=0 and alloc_tag holds its last value.
- Completion:
  - cpl_valid & cpl_end on a busy tag: busy<=0 next edge.
  - cpl_valid & !cpl_end: no state change.
  - cpl_valid on a non-busy tag: cpl_err_flg pulses one cycle; no state change.
  - Completion on a busy, timed_out tag (recovery off) frees it normally.
- Simultaneous alloc and free of different tags: free_cnt unchanged. The same tag cannot collide, because only free tags are granted.
- free_cnt is a registered count: +1 per free, -1 per grant.
- Timeout FSM:
  - SCAN: examines scan_idx once per cycle. If busy & !timed_out & tout_set!=0 & ((now_tick - stamp) mod 2^TOUT_W) >= tout_set, latch tout_tag=scan_idx, assert tout_valid, go to REPORT. Otherwise scan_idx++ with wrap MAXTAG-1 -> 0.
  - REPORT: hold tout_valid/tout_tag stable until tout_ready.
  - On handshake: set timed_out; if iTAG_recovery (sampled at handshake), busy<=0; set tag_timeout_flg_dbg; scan_idx++; return to SCAN.
  - If the tag is freed by completion while in REPORT, the report still completes, with no double free and no free_cnt change.
- Detection latency: at most MAXTAG cycles after the threshold is crossed, plus one tick of quantisation. Thresholds near 2^TOUT_W-1 alias because of modulo age.
- Changing iTAG_tout_set takes effect from the next scanned tag.

Test Plan:
- Reset, then 64 back-to-back alloc_req with MAXTAG=64 -> tags 0..63 in order, free_cnt 64->0; 65th request gets alloc_gnt=0.
- Free tags 5 and 2 via cpl_end, then alloc -> tag 2 then tag 5; a cpl_valid & !cpl_end on tag 9 leaves free_cnt unchanged.
- Same cycle: alloc (tag 10) and cpl_end on tag 3 -> free_cnt unchanged, both bits updated next edge.
- TICK_DIV=4, tout_set=2, recovery=1, alloc tag 0, no completion -> tout_valid for tag 0 within 8+64 cycles; held 5 cycles with tout_ready=0; on accept, free_cnt+1 and flag sticky.
- Same setup with recovery=0 -> tag 0 reported once only, stays busy; a later cpl_end on tag 0 frees it with no cpl_err_flg.
- cpl_end for free tag 7 -> cpl_err_flg one-cycle pulse. pcie_rst_n low mid-REPORT -> tout_valid=0 immediately, free_cnt=64.

Source files
------------

// File: rtl/pcie_rd_tag_mgr.sv
// Non-posted read tag manager: lowest-free tag allocation, retirement on the final
// completion, and a round-robin timeout scanner with a backpressured report channel.
module pcie_rd_tag_mgr #(
    parameter  int MAXTAG   = 64,
    parameter  int TOUT_W   = 16,
    parameter  int TICK_DIV = 1024,
    localparam int TAGW     = $clog2(MAXTAG)
) (
    input  logic              pcie_clk,
    input  logic              pcie_rst_n,
    input  logic              iTAG_recovery,
    input  logic [TOUT_W-1:0] iTAG_tout_set,
    input  logic              alloc_req,
    output logic              alloc_gnt,
    output logic [TAGW-1:0]   alloc_tag,
    input  logic              cpl_valid,
    input  logic [TAGW-1:0]   cpl_tag,
    input  logic              cpl_end,
    output logic              tout_valid,
    output logic [TAGW-1:0]   tout_tag,
    input  logic              tout_ready,
    output logic [TAGW:0]     free_cnt,
    output logic              cpl_err_flg,
    output logic              tag_timeout_flg_dbg
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic {
        ST_SCAN,
        ST_REPORT
    } state_t;

    state_t            state_q, state_d;
    logic [MAXTAG-1:0] busy_q, busy_d;
    logic [MAXTAG-1:0] tmo_q, tmo_d;
    logic [TOUT_W-1:0] stamp_q [MAXTAG];
    logic [PW-1:0]     presc_q;
    logic [TOUT_W-1:0] now_tick_q;
    logic [TAGW:0]     free_cnt_q, free_cnt_d;
    logic [TAGW-1:0]   scan_idx_q;
    logic [TAGW-1:0]   tout_tag_q;
    logic [TAGW-1:0]   last_tag_q;
    logic              stale_q;
    logic              err_q;
    logic              flg_q;

    logic [TAGW-1:0]   low_tag;
    logic              any_free;
    logic              cpl_free;
    logic              scan_hit;
    logic              hs;
    logic              tout_cpl_free;
    logic              rec_free;
    logic [TOUT_W-1:0] age;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        low_tag  = '0;
        any_free = 1'b0;
        for (int i = MAXTAG - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                low_tag  = TAGW'(i);
                any_free = 1'b1;
            end
        end
    end

    assign alloc_gnt = alloc_req & (free_cnt_q != '0);
    assign alloc_tag = any_free ? low_tag : last_tag_q;

    assign cpl_free = cpl_valid & cpl_end & busy_q[cpl_tag];

    // Modulo age keeps working across now_tick wrap.
    assign age      = now_tick_q - stamp_q[scan_idx_q];
    assign scan_hit = busy_q[scan_idx_q] & ~tmo_q[scan_idx_q]
                    & (iTAG_tout_set != '0) & (age >= iTAG_tout_set)
                    & ~(cpl_free & (cpl_tag == scan_idx_q));

    assign hs            = (state_q == ST_REPORT) & tout_ready;
    assign tout_cpl_free = cpl_free & (cpl_tag == tout_tag_q);
    // A tag already retired (and possibly re-granted) during the report is left alone.
    assign rec_free      = hs & iTAG_recovery & ~stale_q & busy_q[tout_tag_q] & ~tout_cpl_free;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SCAN:   if (scan_hit)   state_d = ST_REPORT;
            ST_REPORT: if (tout_ready) state_d = ST_SCAN;
            default:                   state_d = ST_SCAN;
        endcase
    end

    always_comb begin
        busy_d = busy_q;
        tmo_d  = tmo_q;
        if (cpl_free) busy_d[cpl_tag] = 1'b0;
        if (rec_free) busy_d[tout_tag_q] = 1'b0;
        if (hs && !stale_q) tmo_d[tout_tag_q] = 1'b1;
        if (alloc_gnt) begin
            busy_d[alloc_tag] = 1'b1;
            tmo_d[alloc_tag]  = 1'b0;
        end
        free_cnt_d = free_cnt_q + (TAGW+1)'(cpl_free) + (TAGW+1)'(rec_free)
                   - (TAGW+1)'(alloc_gnt);
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge pcie_clk or negedge pcie_rst_n) begin
        if (!pcie_rst_n) begin
            state_q    <= ST_SCAN;
            busy_q     <= '0;
            tmo_q      <= '0;
            presc_q    <= '0;
            now_tick_q <= '0;
            free_cnt_q <= (TAGW+1)'(MAXTAG);
            scan_idx_q <= '0;
            tout_tag_q <= '0;
            last_tag_q <= '0;
            stale_q    <= 1'b0;
            err_q      <= 1'b0;
            flg_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            busy_q     <= busy_d;
            tmo_q      <= tmo_d;
            free_cnt_q <= free_cnt_d;
            last_tag_q <= alloc_tag;
            err_q      <= cpl_valid & ~busy_q[cpl_tag];
            flg_q      <= flg_q | hs;
            stale_q    <= (state_q == ST_SCAN) ? 1'b0 : (stale_q | tout_cpl_free);

            if (presc_q == PW'(TICK_DIV - 1)) begin
                presc_q    <= '0;
                now_tick_q <= now_tick_q + 1'b1;
            end else begin
                presc_q <= presc_q + 1'b1;
            end

            if (state_q == ST_SCAN) begin
                if (scan_hit) tout_tag_q <= scan_idx_q;
                else          scan_idx_q <= scan_idx_q + 1'b1;
            end else if (hs) begin
                scan_idx_q <= scan_idx_q + 1'b1;
            end
        end
    end

    // NOTE: timestamps are qualified by busy, so this storage needs no reset and can map to RAM.
    always_ff @(posedge pcie_clk) begin
        if (alloc_gnt) stamp_q[alloc_tag] <= now_tick_q;
    end

    assign tout_valid          = (state_q == ST_REPORT);
    assign tout_tag            = tout_tag_q;
    assign free_cnt            = free_cnt_q;
    assign cpl_err_flg         = err_q;
    assign tag_timeout_flg_dbg = flg_q;

endmodule

// File: tb/tb_pcie_rd_tag_mgr.sv
// Testbench for pcie_rd_tag_mgr: a tag-set reference model scores allocation and
// completion traffic; timeout scenarios are checked against their timing bounds.
module tb_pcie_rd_tag_mgr;

    localparam int MAXTAG   = 64;
    localparam int TAGW     = 6;
    localparam int TOUT_W   = 16;
    localparam int TICK_DIV = 4;

    logic              pcie_clk = 1'b0;
    logic              pcie_rst_n = 1'b0;
    logic              iTAG_recovery = 1'b0;
    logic [TOUT_W-1:0] iTAG_tout_set = '0;
    logic              alloc_req = 1'b0;
    logic              alloc_gnt;
    logic [TAGW-1:0]   alloc_tag;
    logic              cpl_valid = 1'b0;
    logic [TAGW-1:0]   cpl_tag = '0;
    logic              cpl_end = 1'b0;
    logic              tout_valid;
    logic [TAGW-1:0]   tout_tag;
    logic              tout_ready = 1'b0;
    logic [TAGW:0]     free_cnt;
    logic              cpl_err_flg;
    logic              tag_timeout_flg_dbg;

    pcie_rd_tag_mgr #(
        .MAXTAG  (MAXTAG),
        .TOUT_W  (TOUT_W),
        .TICK_DIV(TICK_DIV)
    ) dut (
        .pcie_clk           (pcie_clk),
        .pcie_rst_n         (pcie_rst_n),
        .iTAG_recovery      (iTAG_recovery),
        .iTAG_tout_set      (iTAG_tout_set),
        .alloc_req          (alloc_req),
        .alloc_gnt          (alloc_gnt),
        .alloc_tag          (alloc_tag),
        .cpl_valid          (cpl_valid),
        .cpl_tag            (cpl_tag),
        .cpl_end            (cpl_end),
        .tout_valid         (tout_valid),
        .tout_tag           (tout_tag),
        .tout_ready         (tout_ready),
        .free_cnt           (free_cnt),
        .cpl_err_flg        (cpl_err_flg),
        .tag_timeout_flg_dbg(tag_timeout_flg_dbg)
    );

    always #5 pcie_clk = ~pcie_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: the set of outstanding tags plus the pending error pulse.
    bit [MAXTAG-1:0] m_busy;
    bit              m_err;
    int              m_prev_tag;

    logic            obs_gnt;
    logic [TAGW-1:0] obs_tag;
    logic [TAGW:0]   obs_free;
    logic            obs_err;

    task automatic do_reset();
        alloc_req  = 1'b0;
        cpl_valid  = 1'b0;
        cpl_end    = 1'b0;
        cpl_tag    = '0;
        tout_ready = 1'b0;
        @(negedge pcie_clk);
        pcie_rst_n = 1'b0;
        repeat (3) @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
        m_busy     = '0;
        m_err      = 1'b0;
        m_prev_tag = 0;
    endtask

    // One clock of traffic: drive at the falling edge, score against the model, then
    // advance the model by the rules that apply at the next rising edge.
    task automatic drive_cycle(input logic req, input logic cv, input logic [TAGW-1:0] ct,
                               input logic ce);
        int   exp_free;
        int   exp_tag;
        logic exp_gnt;
        bit   found;
        @(negedge pcie_clk);
        alloc_req = req;
        cpl_valid = cv;
        cpl_tag   = ct;
        cpl_end   = ce;
        #1;
        exp_free = 0;
        found    = 1'b0;
        exp_tag  = m_prev_tag;
        for (int i = MAXTAG - 1; i >= 0; i--) begin
            if (!m_busy[i]) begin
                exp_free++;
                exp_tag = i;
                found   = 1'b1;
            end
        end
        exp_gnt  = req && (exp_free != 0);
        obs_gnt  = alloc_gnt;
        obs_tag  = alloc_tag;
        obs_free = free_cnt;
        obs_err  = cpl_err_flg;
        n_tests++;
        if (alloc_gnt !== exp_gnt) begin
            n_fail++;
            $display("FAIL alloc_gnt: got %0b expected %0b", alloc_gnt, exp_gnt);
        end
        if (exp_gnt || !found) begin
            n_tests++;
            if (alloc_tag !== TAGW'(exp_tag)) begin
                n_fail++;
                $display("FAIL alloc_tag: got %0d expected %0d", alloc_tag, exp_tag);
            end
        end
        n_tests++;
        if (free_cnt !== (TAGW+1)'(exp_free)) begin
            n_fail++;
            $display("FAIL free_cnt: got %0d expected %0d", free_cnt, exp_free);
        end
        n_tests++;
        if (cpl_err_flg !== m_err) begin
            n_fail++;
            $display("FAIL cpl_err_flg: got %0b expected %0b", cpl_err_flg, m_err);
        end
        m_err = cv && !m_busy[ct];
        if (cv && ce && m_busy[ct]) m_busy[ct] = 1'b0;
        if (exp_gnt) m_busy[exp_tag] = 1'b1;
        m_prev_tag = exp_tag;
    endtask

    task automatic test_reset();
        iTAG_tout_set = '0;
        iTAG_recovery = 1'b0;
        do_reset();
        #1;
        n_tests++;
        if (free_cnt !== 7'd64 || alloc_gnt !== 1'b0 || alloc_tag !== '0 || tout_valid !== 1'b0
            || tout_tag !== '0 || cpl_err_flg !== 1'b0 || tag_timeout_flg_dbg !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state: got free=%0d gnt=%0b tag=%0d tv=%0b tt=%0d err=%0b flg=%0b expected 64/0/0/0/0/0/0",
                     free_cnt, alloc_gnt, alloc_tag, tout_valid, tout_tag, cpl_err_flg,
                     tag_timeout_flg_dbg);
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < MAXTAG; i++) begin
            drive_cycle(1'b1, 1'b0, '0, 1'b0);
            n_tests++;
            if (obs_tag !== TAGW'(i)) begin
                n_fail++;
                $display("FAIL fill_order: got %0d expected %0d", obs_tag, i);
            end
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_gnt !== 1'b0 || obs_free !== '0) begin
            n_fail++;
            $display("FAIL fill_exhausted: got gnt=%0b free=%0d expected gnt=0 free=0",
                     obs_gnt, obs_free);
        end
    endtask

    task automatic test_free_order();
        drive_cycle(1'b0, 1'b1, 6'd5, 1'b1);
        drive_cycle(1'b0, 1'b1, 6'd2, 1'b1);
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_tag !== 6'd2) begin
            n_fail++;
            $display("FAIL realloc_first: got %0d expected 2", obs_tag);
        end
        drive_cycle(1'b1, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_tag !== 6'd5) begin
            n_fail++;
            $display("FAIL realloc_second: got %0d expected 5", obs_tag);
        end
        drive_cycle(1'b0, 1'b1, 6'd9, 1'b0);
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_free !== '0) begin
            n_fail++;
            $display("FAIL partial_cpl: got free=%0d expected 0", obs_free);
        end
    endtask

    task automatic test_back_to_back();
        drive_cycle(1'b0, 1'b1, 6'd10, 1'b1);
        drive_cycle(1'b1, 1'b1, 6'd3, 1'b1);
        n_tests++;
        if (obs_gnt !== 1'b1 || obs_tag !== 6'd10) begin
            n_fail++;
            $display("FAIL simul_grant: got gnt=%0b tag=%0d expected 1/10", obs_gnt, obs_tag);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_free !== 7'd1 || obs_tag !== 6'd3) begin
            n_fail++;
            $display("FAIL simul_free: got free=%0d tag=%0d expected 1/3", obs_free, obs_tag);
        end
    endtask

    task automatic test_cpl_err();
        drive_cycle(1'b0, 1'b1, 6'd7, 1'b1);
        drive_cycle(1'b0, 1'b1, 6'd7, 1'b1);
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_err !== 1'b1) begin
            n_fail++;
            $display("FAIL err_pulse: got %0b expected 1", obs_err);
        end
        drive_cycle(1'b0, 1'b0, '0, 1'b0);
        n_tests++;
        if (obs_err !== 1'b0) begin
            n_fail++;
            $display("FAIL err_one_cycle: got %0b expected 0", obs_err);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 400; n++) begin
            drive_cycle(($urandom_range(0, 9) < 6), ($urandom_range(0, 9) < 4),
                        TAGW'($urandom_range(0, MAXTAG - 1)), ($urandom_range(0, 9) < 7));
        end
    endtask

    task automatic wait_report(output bit seen);
        int waited;
        @(negedge pcie_clk);
        alloc_req = 1'b1;
        #1;
        n_tests++;
        if (alloc_gnt !== 1'b1 || alloc_tag !== '0) begin
            n_fail++;
            $display("FAIL tout_alloc: got gnt=%0b tag=%0d expected 1/0", alloc_gnt, alloc_tag);
        end
        @(negedge pcie_clk);
        alloc_req = 1'b0;
        waited = 1;
        while (tout_valid !== 1'b1 && waited < 8 + 64 + 2) begin
            @(negedge pcie_clk);
            waited++;
        end
        seen = (tout_valid === 1'b1);
    endtask

    task automatic test_timeout(input logic recovery);
        bit seen;
        int extra;
        do_reset();
        iTAG_tout_set = 16'd2;
        iTAG_recovery = recovery;
        wait_report(seen);
        n_tests++;
        if (!seen || tout_tag !== '0) begin
            n_fail++;
            $display("FAIL tout_detect: got valid=%0b tag=%0d expected 1/0", tout_valid, tout_tag);
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge pcie_clk);
            n_tests++;
            if (tout_valid !== 1'b1 || tout_tag !== '0) begin
                n_fail++;
                $display("FAIL tout_hold: got valid=%0b tag=%0d expected 1/0", tout_valid, tout_tag);
            end
        end
        tout_ready = 1'b1;
        @(negedge pcie_clk);
        tout_ready = 1'b0;
        n_tests++;
        if (tout_valid !== 1'b0 || tag_timeout_flg_dbg !== 1'b1
            || free_cnt !== (recovery ? 7'd64 : 7'd63)) begin
            n_fail++;
            $display("FAIL tout_accept: got valid=%0b flg=%0b free=%0d expected 0/1/%0d",
                     tout_valid, tag_timeout_flg_dbg, free_cnt, recovery ? 64 : 63);
        end
        extra = 0;
        for (int k = 0; k < 150; k++) begin
            @(negedge pcie_clk);
            if (tout_valid === 1'b1) extra++;
        end
        n_tests++;
        if (extra != 0 || tag_timeout_flg_dbg !== 1'b1) begin
            n_fail++;
            $display("FAIL tout_once: got extra=%0d flg=%0b expected 0/1", extra, tag_timeout_flg_dbg);
        end
        if (!recovery) begin
            cpl_valid = 1'b1;
            cpl_tag   = '0;
            cpl_end   = 1'b1;
            @(negedge pcie_clk);
            cpl_valid = 1'b0;
            cpl_end   = 1'b0;
            n_tests++;
            if (cpl_err_flg !== 1'b0 || free_cnt !== 7'd64) begin
                n_fail++;
                $display("FAIL tout_late_cpl: got err=%0b free=%0d expected 0/64", cpl_err_flg, free_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_report();
        bit seen;
        do_reset();
        iTAG_tout_set = 16'd2;
        iTAG_recovery = 1'b1;
        wait_report(seen);
        n_tests++;
        if (!seen) begin
            n_fail++;
            $display("FAIL rst_report_setup: got valid=%0b expected 1", tout_valid);
        end
        #2;
        pcie_rst_n = 1'b0;
        #1;
        n_tests++;
        if (tout_valid !== 1'b0 || free_cnt !== 7'd64 || tag_timeout_flg_dbg !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_report: got valid=%0b free=%0d flg=%0b expected 0/64/0",
                     tout_valid, free_cnt, tag_timeout_flg_dbg);
        end
        @(negedge pcie_clk);
        pcie_rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_fill();
        test_free_order();
        test_back_to_back();
        test_cpl_err();
        test_random();
        test_timeout(1'b1);
        test_timeout(1'b0);
        test_reset_mid_report();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
